// File: rtl/mem_port_arb_pkg.sv
// Shared encodings for the external memory port arbiter: FSM states, access sizes, sources.
// Also holds the helper that decodes ME size flags into an ext_size code.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_HOLD_ME = 2'd1,
        ARB_HOLD_IF = 2'd2
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_DBL  = 2'b11;

    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_ME = 1'b1;

    // Conflicting flags resolve as double > byte > halfword.
    function automatic logic [1:0] me_size(input logic is_dbl, input logic is_byte,
                                           input logic is_half);
        logic [1:0] sz;
        if (is_dbl) begin
            sz = SZ_DBL;
        end else if (is_byte) begin
            sz = SZ_BYTE;
        end else if (is_half) begin
            sz = SZ_HALF;
        end else begin
            sz = SZ_WORD;
        end
        return sz;
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Wait-state counter for a held memory access: clear, load-to-one, increment,
// and a terminal-count flag when the count reaches TIMEOUT.
module arb_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] TermCnt = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CntOne;
        end else if (en_i) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == TermCnt);

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates the single external memory port between instruction fetch and the ME stage,
// stalls the pipeline via nWAIT until every access due this pipeline cycle has completed.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        nGCLK,
    input  logic        nRESET,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        me_ena,
    input  logic        me_rd_wr,
    input  logic [31:0] me_addr,
    input  logic        me_byte,
    input  logic        me_halfword,
    input  logic        me_double,
    input  logic        ext_ack,
    output logic        ext_req,
    output logic [31:0] ext_addr,
    output logic        ext_rd_wr,
    output logic [1:0]  ext_size,
    output logic        ext_src,
    output logic        if_done,
    output logic        me_done,
    output logic        if_abort,
    output logic        me_abort,
    output logic        nWAIT
);

    arb_state_e state_q, state_d;
    logic       me_served_q, me_served_d;
    logic       if_served_q, if_served_d;

    logic             pend_me, pend_if;
    logic             req, src_me;
    logic             me_fin, if_fin, me_ab, if_ab;
    logic             cnt_clr, cnt_load, cnt_en, cnt_tc;
    logic [CNT_W-1:0] cnt;

    assign pend_me = me_ena & ~me_served_q;
    assign pend_if = if_req & ~if_served_q;

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_cnt (
        .clk_i  (nGCLK),
        .rst_ni (nRESET),
        .clr_i  (cnt_clr),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .cnt_o  (cnt),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        src_me   = SRC_IF;
        me_fin   = 1'b0;
        if_fin   = 1'b0;
        me_ab    = 1'b0;
        if_ab    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                // Combinational grant lets a zero-wait access finish in its request cycle.
                if (pend_me || pend_if) begin
                    req    = 1'b1;
                    src_me = pend_me;
                    if (ext_ack) begin
                        me_fin = pend_me;
                        if_fin = ~pend_me;
                    end else begin
                        state_d  = pend_me ? ARB_HOLD_ME : ARB_HOLD_IF;
                        cnt_load = 1'b1;
                    end
                end
            end
            ARB_HOLD_ME: begin
                if (!me_ena) begin
                    state_d = ARB_IDLE;
                    cnt_clr = 1'b1;
                end else begin
                    req    = 1'b1;
                    src_me = SRC_ME;
                    if (ext_ack) begin
                        me_fin  = 1'b1;
                        state_d = ARB_IDLE;
                        cnt_clr = 1'b1;
                    end else if (cnt_tc) begin
                        me_fin  = 1'b1;
                        me_ab   = 1'b1;
                        state_d = ARB_IDLE;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ARB_HOLD_IF: begin
                if (!if_req) begin
                    state_d = ARB_IDLE;
                    cnt_clr = 1'b1;
                end else begin
                    req    = 1'b1;
                    src_me = SRC_IF;
                    if (ext_ack) begin
                        if_fin  = 1'b1;
                        state_d = ARB_IDLE;
                        cnt_clr = 1'b1;
                    end else if (cnt_tc) begin
                        if_fin  = 1'b1;
                        if_ab   = 1'b1;
                        state_d = ARB_IDLE;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Reset gates the handshake outputs so a live request cannot leak onto the port.
    assign ext_req  = req & nRESET;
    assign me_done  = me_fin & nRESET;
    assign if_done  = if_fin & nRESET;
    assign me_abort = me_ab & nRESET;
    assign if_abort = if_ab & nRESET;

    always_comb begin
        ext_addr  = '0;
        ext_src   = SRC_IF;
        ext_rd_wr = 1'b1;
        ext_size  = SZ_WORD;
        if (ext_req) begin
            ext_src = src_me;
            if (src_me) begin
                ext_addr  = me_addr;
                ext_rd_wr = me_rd_wr;
                ext_size  = me_size(me_double, me_byte, me_halfword);
            end else begin
                ext_addr = if_addr;
            end
        end
    end

    assign nWAIT = ~((if_req & ~if_served_q & ~if_done) | (me_ena & ~me_served_q & ~me_done));

    // A released pipeline edge starts a new pipeline cycle; clear beats set.
    always_comb begin
        me_served_d = 1'b0;
        if_served_d = 1'b0;
        if (!nWAIT) begin
            me_served_d = me_served_q | me_done;
            if_served_d = if_served_q | if_done;
        end
    end

    always_ff @(posedge nGCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= ARB_IDLE;
            me_served_q <= 1'b0;
            if_served_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            me_served_q <= me_served_d;
            if_served_q <= if_served_d;
        end
    end

endmodule
